// File: rtl/seg_digit_source_if.sv
// seg_digit_source_if: bundles the control inputs and display-side outputs of
// seg_digit_source.
//   master: drives v_sync, run, up, load, load_val; observes ce, seg, digit, step
//   slave : the digit source itself
interface seg_digit_source_if;
    logic       v_sync;    // vertical sync from the display, active-low pulse
    logic       run;       // 1 = frame counting advances the digit
    logic       up;        // 1 = increment, 0 = decrement
    logic       load;      // one-clock load request
    logic [3:0] load_val;  // value to load
    logic       ce;        // pixel clock enable
    logic [6:0] seg;       // {a,b,c,d,e,f,g}, active-high
    logic [3:0] digit;     // current digit
    logic       step;      // one-clock pulse on step or load

    modport master (
        output v_sync, run, up, load, load_val,
        input  ce, seg, digit, step
    );

    modport slave (
        input  v_sync, run, up, load, load_val,
        output ce, seg, digit, step
    );
endinterface

// File: rtl/seg_digit_source.sv
// seg_digit_source: single-digit source for a VGA seven-segment display.
// Holds a digit that steps once every FRAMES_PER_STEP frames (counted on the
// falling edge of v_sync), decodes it to seven-segment form and only updates
// seg in the cycle after a v_sync fall so a frame is never drawn torn.
// Also generates the pixel clock enable ce (1 of every CE_DIV clocks).
//   clk_i  : system clock
//   rst_ni : synchronous active-low reset
//   bus_io : seg_digit_source_if.slave (v_sync/run/up/load/load_val in,
//            ce/seg/digit/step out)
module seg_digit_source #(
    parameter int unsigned CE_DIV          = 1,
    parameter int unsigned FRAMES_PER_STEP = 60,
    parameter int unsigned HEX_MODE        = 0,
    parameter int unsigned INIT_DIGIT      = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    seg_digit_source_if.slave     bus_io
);

    localparam int unsigned CeW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int unsigned FcW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CeW-1:0] CeMax    = CeW'(CE_DIV - 1);
    localparam logic [FcW-1:0] FcMax    = FcW'(FRAMES_PER_STEP - 1);
    localparam logic [3:0]     DigitMax = (HEX_MODE != 0) ? 4'hF : 4'd9;
    localparam logic [3:0]     InitVal  = 4'(INIT_DIGIT);

    typedef enum logic [1:0] {StWait, StRun, StHold} state_e;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    state_e         state_q;
    logic [CeW-1:0] ce_cnt_q;
    logic           ce_q;
    logic           v_q;
    logic           tick_q;
    logic [FcW-1:0] fcnt_q;
    logic           load_pend_q;
    logic [3:0]     load_val_q;
    logic [3:0]     digit_q;
    logic [6:0]     seg_q;
    logic           step_q;

    logic [3:0] digit_step_d;
    logic [3:0] load_sat_d;
    logic       fcnt_last_d;

    always_comb begin
        digit_step_d = digit_q;
        if (bus_io.up) begin
            digit_step_d = (digit_q == DigitMax) ? 4'd0 : digit_q + 4'd1;
        end else begin
            digit_step_d = (digit_q == 4'd0) ? DigitMax : digit_q - 4'd1;
        end
        // In decimal mode anything above 9 is clamped rather than wrapped.
        load_sat_d  = (bus_io.load_val > DigitMax) ? DigitMax : bus_io.load_val;
        fcnt_last_d = (fcnt_q == FcMax);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StWait;
            ce_cnt_q    <= '0;
            ce_q        <= 1'b0;
            v_q         <= 1'b0;
            tick_q      <= 1'b0;
            fcnt_q      <= '0;
            load_pend_q <= 1'b0;
            load_val_q  <= 4'd0;
            digit_q     <= InitVal;
            seg_q       <= decode(InitVal);
            step_q      <= 1'b0;
        end else begin
            ce_cnt_q <= (ce_cnt_q == CeMax) ? '0 : ce_cnt_q + 1'b1;
            ce_q     <= (ce_cnt_q == CeMax);

            // v_q resets low so a v_sync already low at release is not an edge.
            v_q    <= bus_io.v_sync;
            tick_q <= v_q & ~bus_io.v_sync;

            step_q <= 1'b0;
            if (tick_q) begin
                // A pending load wins over a step due on the same tick.
                if (load_pend_q) begin
                    digit_q <= load_val_q;
                    seg_q   <= decode(load_val_q);
                    fcnt_q  <= '0;
                    step_q  <= 1'b1;
                end else if (state_q == StRun) begin
                    if (fcnt_last_d) begin
                        fcnt_q  <= '0;
                        digit_q <= digit_step_d;
                        seg_q   <= decode(digit_step_d);
                        step_q  <= 1'b1;
                    end else begin
                        fcnt_q <= fcnt_q + 1'b1;
                    end
                end
                load_pend_q <= 1'b0;
            end

            // A load coinciding with the applying tick stays pending (later NBA wins).
            if (bus_io.load) begin
                load_pend_q <= 1'b1;
                load_val_q  <= load_sat_d;
            end

            unique case (state_q)
                StWait: begin
                    if (tick_q) begin
                        state_q <= bus_io.run ? StRun : StHold;
                    end
                end
                StRun: begin
                    if (!bus_io.run) begin
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (bus_io.run) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StWait;
            endcase
        end
    end

    assign bus_io.ce    = ce_q;
    assign bus_io.seg   = seg_q;
    assign bus_io.digit = digit_q;
    assign bus_io.step  = step_q;

endmodule

// File: tb/tb_seg_digit_source.sv
module tb_seg_digit_source;

    logic clk = 1'b0;
    logic rst_na;
    logic rst_nb;
    always #5 clk = ~clk;

    // Instance a: decimal, 2 frames per step, CE_DIV 1, init 0.
    // Instance b: hex, 1 frame per step, CE_DIV 4, init 7.
    seg_digit_source_if ifa ();
    seg_digit_source_if ifb ();

    seg_digit_source #(
        .CE_DIV(1), .FRAMES_PER_STEP(2), .HEX_MODE(0), .INIT_DIGIT(0)
    ) dut_a (
        .clk_i (clk),
        .rst_ni(rst_na),
        .bus_io(ifa)
    );

    seg_digit_source #(
        .CE_DIV(4), .FRAMES_PER_STEP(1), .HEX_MODE(1), .INIT_DIGIT(7)
    ) dut_b (
        .clk_i (clk),
        .rst_ni(rst_nb),
        .bus_io(ifb)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;   1: return 7'b0110000;
            2: return 7'b1101101;   3: return 7'b1111001;
            4: return 7'b0110011;   5: return 7'b1011011;
            6: return 7'b1011111;   7: return 7'b1110000;
            8: return 7'b1111111;   9: return 7'b1111011;
            10: return 7'b1110111;  11: return 7'b0011111;
            12: return 7'b1001110;  13: return 7'b0111101;
            14: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    function automatic int p_ce(input int i);   return (i == 0) ? 1 : 4; endfunction
    function automatic int p_fps(input int i);  return (i == 0) ? 2 : 1; endfunction
    function automatic int p_mod(input int i);  return (i == 0) ? 10 : 16; endfunction
    function automatic int p_init(input int i); return (i == 0) ? 0 : 7; endfunction

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for first frame, 1 running, 2 held
    int m_digit [2];
    int m_frames[2];
    int m_cecnt [2];
    int m_mode  [2];
    int m_pval  [2];
    bit m_pend  [2];
    bit m_vprev [2];
    bit m_fell  [2];
    bit e_ce    [2];
    bit e_step  [2];

    task automatic model_edge(input int i, input bit rn, input bit vs, input bit run,
                              input bit up, input bit ld, input int lv);
        if (!rn) begin
            m_digit[i] = p_init(i); m_frames[i] = 0; m_cecnt[i] = 0; m_mode[i] = 0;
            m_pval[i] = 0; m_pend[i] = 0; m_vprev[i] = 0; m_fell[i] = 0;
            e_ce[i] = 0; e_step[i] = 0;
            return;
        end
        e_ce[i]    = (m_cecnt[i] == p_ce(i) - 1);
        m_cecnt[i] = (m_cecnt[i] + 1) % p_ce(i);
        e_step[i]  = 0;
        if (m_fell[i]) begin
            if (m_pend[i]) begin
                m_digit[i] = m_pval[i]; m_frames[i] = 0; e_step[i] = 1; m_pend[i] = 0;
            end else if (m_mode[i] == 1) begin
                m_frames[i]++;
                if (m_frames[i] == p_fps(i)) begin
                    m_frames[i] = 0;
                    m_digit[i] = up ? (m_digit[i] + 1) % p_mod(i)
                                    : (m_digit[i] + p_mod(i) - 1) % p_mod(i);
                    e_step[i] = 1;
                end
            end
        end
        if (m_mode[i] == 0) m_mode[i] = m_fell[i] ? (run ? 1 : 2) : 0;
        else                m_mode[i] = run ? 1 : 2;
        if (ld) begin
            m_pend[i] = 1;
            m_pval[i] = (lv >= p_mod(i)) ? p_mod(i) - 1 : lv;
        end
        m_fell[i]  = m_vprev[i] && !vs;
        m_vprev[i] = vs;
    endtask

    initial forever begin
        @(posedge clk);
        model_edge(0, rst_na, ifa.v_sync, ifa.run, ifa.up, ifa.load, int'(ifa.load_val));
        model_edge(1, rst_nb, ifb.v_sync, ifb.run, ifb.up, ifb.load, int'(ifb.load_val));
    end

    // ---------------- per-cycle compare ----------------
    int a_steps = 0;
    int a_seq[$];

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("a.ce",    32'(ifa.ce),    32'(e_ce[0]));
            chk("a.step",  32'(ifa.step),  32'(e_step[0]));
            chk("a.digit", 32'(ifa.digit), 32'(m_digit[0]));
            chk("a.seg",   32'(ifa.seg),   32'(seg_of(m_digit[0])));
            chk("b.ce",    32'(ifb.ce),    32'(e_ce[1]));
            chk("b.step",  32'(ifb.step),  32'(e_step[1]));
            chk("b.digit", 32'(ifb.digit), 32'(m_digit[1]));
            chk("b.seg",   32'(ifb.seg),   32'(seg_of(m_digit[1])));
            if (ifa.step === 1'b1) begin
                a_steps++;
                a_seq.push_back(int'(ifa.digit));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_vs(input int i, input logic v);
        if (i == 0) ifa.v_sync = v;
        else        ifb.v_sync = v;
    endtask

    // v_sync high for 3 clocks, then low for 3 clocks.
    task automatic frame(input int i);
        @(negedge clk);
        set_vs(i, 1'b1);
        repeat (3) @(negedge clk);
        set_vs(i, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        ifa.v_sync = 0; ifa.run = 0; ifa.up = 1; ifa.load = 0; ifa.load_val = 0;
        ifb.v_sync = 0; ifb.run = 0; ifb.up = 1; ifb.load = 0; ifb.load_val = 0;
        rst_na = 0; rst_nb = 0;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_na = 1; rst_nb = 1;

        // Reset release with v_sync low: b holds 7, ce 0,0,0,1 pattern.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("b.ce_pattern", 32'(ifb.ce), 32'((k % 4) == 3));
            chk("b.hold_seg", 32'(ifb.seg), 32'(7'b1110000));
            chk("b.no_step", 32'(ifb.step), 32'd0);
        end
        chk("a.ce_const", 32'(ifa.ce), 32'd1);

        // a: 22 frames, FRAMES_PER_STEP=2, counting up.
        ifa.run = 1;
        a_steps = 0;
        a_seq.delete();
        repeat (22) frame(0);
        chk("a.step_count", 32'(a_steps), 32'd10);
        chk("a.end_digit", 32'(ifa.digit), 32'd0);
        chk("a.end_seg", 32'(ifa.seg), 32'(7'b1111110));
        for (int k = 0; k < a_seq.size() && k < 10; k++)
            chk("a.seq", 32'(a_seq[k]), 32'((k + 1) % 10));

        // a: load 12 mid-frame saturates to 9 at the next fall.
        @(negedge clk);
        ifa.v_sync = 1; ifa.load = 1; ifa.load_val = 4'd12;
        @(negedge clk);
        ifa.load = 0;
        repeat (3) @(negedge clk);
        chk("a.load_wait", 32'(ifa.digit), 32'd0);
        ifa.v_sync = 0;
        repeat (3) @(negedge clk);
        chk("a.load_sat", 32'(ifa.digit), 32'd9);
        chk("a.load_seg", 32'(ifa.seg), 32'(7'b1111011));

        // a: second load before the tick wins.
        @(negedge clk);
        ifa.v_sync = 1; ifa.load = 1; ifa.load_val = 4'd12;
        @(negedge clk);
        ifa.load_val = 4'd3;
        @(negedge clk);
        ifa.load = 0;
        repeat (2) @(negedge clk);
        ifa.v_sync = 0;
        repeat (3) @(negedge clk);
        chk("a.reload", 32'(ifa.digit), 32'd3);

        // a: one frame counted, pause 5 frames, resume: one frame left.
        frame(0);
        chk("a.half", 32'(ifa.digit), 32'd3);
        ifa.run = 0;
        repeat (5) frame(0);
        chk("a.paused", 32'(ifa.digit), 32'd3);
        ifa.run = 1;
        frame(0);
        chk("a.resume", 32'(ifa.digit), 32'd4);

        // b: hex, counting down from a loaded 0.
        @(negedge clk);
        ifb.run = 1; ifb.up = 0; ifb.load = 1; ifb.load_val = 4'd0;
        @(negedge clk);
        ifb.load = 0;
        frame(1);
        chk("b.load0", 32'(ifb.digit), 32'd0);
        @(negedge clk);
        ifb.v_sync = 1;
        repeat (3) @(negedge clk);
        ifb.v_sync = 0;
        @(negedge clk);
        chk("b.lat1_old", 32'(ifb.seg), 32'(7'b1111110));
        @(negedge clk);
        chk("b.lat2_seg", 32'(ifb.seg), 32'(7'b1000111));
        chk("b.lat2_digit", 32'(ifb.digit), 32'd15);
        repeat (2) @(negedge clk);
        frame(1);
        chk("b.down_e", 32'(ifb.seg), 32'(7'b1001111));

        // b: reset mid-count.
        @(negedge clk);
        @(negedge clk);
        rst_nb = 0;
        @(negedge clk);
        chk("b.rst_ce", 32'(ifb.ce), 32'd0);
        chk("b.rst_digit", 32'(ifb.digit), 32'd7);
        rst_nb = 1;
        repeat (6) @(negedge clk);
        chk("b.post_rst", 32'(ifb.digit), 32'd7);
        frame(1);
        chk("b.wait_leave", 32'(ifb.digit), 32'd7);
        frame(1);
        chk("b.resume", 32'(ifb.digit), 32'd6);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
